mac_result_collector: RTL and testbench

Drain-side companion to the pipelined 9-tap MAC. Tracks every operand set issued into the MAC, captures the MAC result exactly LATENCY cycles later, applies optional ReLU and saturation, and buffers results in a FIFO presented on a valid/ready stream. Grants issue credits so results are never lost under downstream backpressure, and flags the end of each output tile.

---
 rtl/mac_collect_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 90 +++++++++
 rtl/mac_result_collector.sv | 154 +++++++++++++++
 tb/tb_mac_result_collector.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_collect_pkg.sv
// mac_collect_pkg
// Shared helpers for the MAC result collector: the count-width helper used
// to size occupancy counters, a ReLU helper and a saturating narrowing
// function. The arithmetic helpers work on a 32-bit signed carrier, so
// IN_WIDTH and OUT_WIDTH must both be at most 32.
package mac_collect_pkg;

  localparam int DEFAULT_DEPTH = 8;

  // Width needed to hold an occupancy count of 0..DEFAULT_DEPTH inclusive.
  localparam int FIFO_CNT_W = $clog2(DEFAULT_DEPTH + 1);

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Clamp negative values to zero when enabled, otherwise pass through.
  function automatic logic signed [31:0] relu(input logic signed [31:0] value,
                                              input logic enable);
    if (enable && (value < 32'sd0)) begin
      return '0;
    end
    return value;
  endfunction

  // Saturate a signed value into the signed range of out_width bits. The
  // caller keeps the low out_width bits of the result.
  function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] value,
                                                    input int out_width);
    longint v;
    longint maxVal;
    longint minVal;
    v      = longint'(value);
    maxVal = (longint'(1) <<< (out_width - 1)) - 1;
    minVal = -(longint'(1) <<< (out_width - 1));
    if (v > maxVal) begin
      return 32'(maxVal);
    end
    if (v < minVal) begin
      return 32'(minVal);
    end
    return value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// First-word-fall-through synchronous FIFO with occupancy count.
// Ports:
//   clk          clock
//   rst_n_i      asynchronous reset, active low (empties the FIFO)
//   push_i       write push_data_i this cycle (ignored when full without pop)
//   push_data_i  data to write
//   pop_i        remove the head entry (ignored when empty)
//   head_o       current head entry, 0 when empty
//   count_o      number of stored entries
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push while full still succeeds when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector
// Drain side of the pipelined MAC. Each accepted issue is tracked for
// LATENCY cycles, then mac_out is captured, optionally ReLU'd, saturated to
// OUT_WIDTH and pushed into a FWFT FIFO presented as a valid/ready stream.
// Issue credits cover both in-flight and buffered results, so a capture
// always finds room in the FIFO.
// Ports:
//   clk              clock
//   arst_n_in        asynchronous reset, active low
//   issue_valid      operand set issued into the MAC this cycle
//   issue_ready      credit available for an issue
//   mac_out          signed MAC result (IN_WIDTH)
//   relu_en          clamp negatives to zero at capture
//   cfg_num_results  results per tile, 0 means 2^CNT_WIDTH
//   out_valid        out_data holds a result
//   out_ready        consumer accepts the result
//   out_data         signed result at the FIFO head (OUT_WIDTH)
//   tile_done        one-cycle pulse after the last pop of a tile
//   overflow_err     sticky protocol/overflow error
module mac_result_collector
  import mac_collect_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int LATENCY   = 5,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [IN_WIDTH-1:0]  mac_out,
  input  logic                 relu_en,
  input  logic [CNT_WIDTH-1:0] cfg_num_results,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 tile_done,
  output logic                 overflow_err
);

  localparam int FCW = count_width(DEPTH);

  logic [LATENCY-1:0]   track_q, track_d;
  logic [FCW-1:0]       inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
  logic [CNT_WIDTH-1:0] tile_cnt_inc;
  logic                 tile_done_q, tile_done_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 capture;
  logic                 pop;
  logic                 violation;
  logic                 fifo_drop;
  logic                 tile_last;
  logic [FCW-1:0]       fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCW:0]         budget_used;

  logic signed [31:0]   mac_ext;
  logic signed [31:0]   mac_relu;
  logic signed [31:0]   mac_sat;
  logic [OUT_WIDTH-1:0] cap_data;
  logic                 unused_sat_parity;

  // Credit covers results still in the MAC plus results already buffered.
  assign budget_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue_ready = (budget_used < (FCW + 1)'(DEPTH));
  assign accept      = issue_valid && issue_ready;
  assign violation   = issue_valid && !issue_ready;
  assign capture     = track_q[LATENCY-1];
  assign pop         = out_valid && out_ready;

  // Capture datapath: sign-extend, optional ReLU, then saturate.
  assign mac_ext           = 32'(signed'(mac_out));
  assign mac_relu          = relu(mac_ext, relu_en);
  assign mac_sat           = sat_narrow(mac_relu, OUT_WIDTH);
  assign cap_data          = mac_sat[OUT_WIDTH-1:0];
  assign unused_sat_parity = ^mac_sat;

  // A full FIFO with no pop cannot take the capture; the credit rule should
  // make this impossible, so it is reported as an error.
  assign fifo_drop = capture && fifo_full && !pop;

  // Pending tracker: new accept enters at bit 0, the top bit is the capture.
  generate
    if (LATENCY == 1) begin : g_track_single
      assign track_d = accept;
    end else begin : g_track_shift
      assign track_d = {track_q[LATENCY-2:0], accept};
    end
  endgenerate

  // A tile counter that wraps to zero naturally matches cfg_num_results of
  // zero, which stands for a full 2^CNT_WIDTH tile.
  assign tile_cnt_inc = tile_cnt_q + 1'b1;
  assign tile_last    = pop && (tile_cnt_inc == cfg_num_results);

  // Next-state for in-flight count, tile counter, tile pulse and error flag.
  always_comb begin
    inflight_d  = inflight_q;
    tile_cnt_d  = tile_cnt_q;
    tile_done_d = tile_last;
    ovf_d       = ovf_q || violation || fifo_drop;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    if (pop) begin
      tile_cnt_d = tile_last ? '0 : tile_cnt_inc;
    end
  end

  // State registers; reset forgets every in-flight result.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      track_q     <= '0;
      inflight_q  <= '0;
      tile_cnt_q  <= '0;
      tile_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      track_q     <= track_d;
      inflight_q  <= inflight_d;
      tile_cnt_q  <= tile_cnt_d;
      tile_done_q <= tile_done_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n_i     (arst_n_in),
    .push_i      (capture),
    .push_data_i (cap_data),
    .pop_i       (pop),
    .head_o      (out_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign tile_done    = tile_done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// tb_mac_result_collector
// Directed scenarios for the MAC result collector with a small MAC delay-line
// model that presents each issued operand value on mac_out LATENCY cycles
// after it was issued.
module tb_mac_result_collector;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        arstN;
  logic        issueValid;
  logic        issueReady;
  logic [15:0] macOut;
  logic        reluEn;
  logic [15:0] cfgNumResults;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outData;
  logic        tileDone;
  logic        overflowErr;

  logic [15:0] issueData;
  logic [15:0] macPipe [LAT];

  int checks   = 0;
  int failures = 0;

  mac_result_collector #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (8),
    .LATENCY   (LAT),
    .DEPTH     (8),
    .CNT_WIDTH (16)
  ) dut (
    .clk             (clk),
    .arst_n_in       (arstN),
    .issue_valid     (issueValid),
    .issue_ready     (issueReady),
    .mac_out         (macOut),
    .relu_en         (reluEn),
    .cfg_num_results (cfgNumResults),
    .out_valid       (outValid),
    .out_ready       (outReady),
    .out_data        (outData),
    .tile_done       (tileDone),
    .overflow_err    (overflowErr)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // MAC model: the value issued in cycle t appears on mac_out during t+LAT.
  always @(posedge clk) begin
    macPipe[0] <= issueData;
    for (int k = 1; k < LAT; k++) begin
      macPipe[k] <= macPipe[k-1];
    end
  end

  assign macOut = macPipe[LAT-1];

  task automatic applyReset();
    arstN         = 1'b0;
    issueValid    = 1'b0;
    issueData     = 16'h0000;
    outReady      = 1'b0;
    reluEn        = 1'b0;
    cfgNumResults = 16'd0;
    repeat (2) @(negedge clk);
    arstN = 1'b1;
    @(negedge clk);
  endtask

  // Issue whenever credit allows, for a fixed number of cycles, with data
  // 1, 2, 3, ... in accept order.
  task automatic applyFill(output int accepts);
    accepts = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      issueValid = issueReady;
      issueData  = 16'(accepts + 1);
      @(negedge clk);
      if (issueValid) accepts++;
    end
    issueValid = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if (issueReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_issue_ready got=%b want=1", issueReady);
    end
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", outValid);
    end
    checks++;
    if (outData !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_out_data got=%h want=00", outData);
    end
    checks++;
    if (tileDone !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_tile_done got=%b want=0", tileDone);
    end
    checks++;
    if (overflowErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_overflow_err got=%b want=0", overflowErr);
    end
  endtask

  task automatic test_single_issue();
    int n;
    applyReset();
    issueValid = 1'b1;
    issueData  = 16'h0042;
    @(negedge clk);
    issueValid = 1'b0;
    n = 1;
    while (!outValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 6) begin
      failures++;
      $display("[TB] FAIL single_latency got=%0d want=6", n);
    end
    checks++;
    if (outData !== 8'h42) begin
      failures++;
      $display("[TB] FAIL single_data got=%h want=42", outData);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_saturation();
    logic [15:0] vin [3];
    logic [7:0]  expSat [2][3];
    vin[0] = 16'd300;
    vin[1] = 16'hFED4;
    vin[2] = 16'hFFFB;
    expSat[0][0] = 8'h7F; expSat[0][1] = 8'h80; expSat[0][2] = 8'hFB;
    expSat[1][0] = 8'h7F; expSat[1][1] = 8'h00; expSat[1][2] = 8'h00;
    for (int mode = 0; mode < 2; mode++) begin
      applyReset();
      reluEn = (mode == 1);
      for (int i = 0; i < 3; i++) begin
        issueValid = 1'b1;
        issueData  = vin[i];
        @(negedge clk);
      end
      issueValid = 1'b0;
      repeat (8) @(negedge clk);
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (outValid !== 1'b1 || outData !== expSat[mode][i]) begin
          failures++;
          $display("[TB] FAIL sat_relu%0d_idx%0d got valid=%b data=%h want valid=1 data=%h",
                   mode, i, outValid, outData, expSat[mode][i]);
        end
        @(negedge clk);
      end
      outReady = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    applyReset();
    applyFill(accepts);
    checks++;
    if (accepts !== 8) begin
      failures++;
      $display("[TB] FAIL bp_accepts got=%0d want=8", accepts);
    end
    checks++;
    if (issueReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_issue_ready_full got=%b want=0", issueReady);
    end
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== 8'(i + 1)) begin
        failures++;
        $display("[TB] FAIL bp_order_idx%0d got valid=%b data=%h want valid=1 data=%h",
                 i, outValid, outData, 8'(i + 1));
      end
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (issueReady !== 1'b1) begin
          failures++;
          $display("[TB] FAIL bp_pop_to_credit got=%b want=1", issueReady);
        end
      end
    end
    outReady = 1'b0;
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drained got=%b want=0", outValid);
    end
    checks++;
    if (overflowErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_overflow got=%b want=0", overflowErr);
    end
  endtask

  task automatic test_protocol_violation();
    int accepts;
    applyReset();
    applyFill(accepts);
    checks++;
    if (overflowErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL viol_pre_overflow got=%b want=0", overflowErr);
    end
    issueValid = 1'b1;
    issueData  = 16'h0099;
    @(negedge clk);
    issueValid = 1'b0;
    checks++;
    if (overflowErr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL viol_overflow_set got=%b want=1", overflowErr);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (overflowErr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL viol_overflow_held got=%b want=1", overflowErr);
    end
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== 8'(i + 1)) begin
        failures++;
        $display("[TB] FAIL viol_contents_idx%0d got valid=%b data=%h want valid=1 data=%h",
                 i, outValid, outData, 8'(i + 1));
      end
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL viol_dropped_not_tracked got=%b want=0", outValid);
    end
    outReady = 1'b0;
  endtask

  task automatic test_tiles();
    int accepts;
    int popIdx;
    int lastPop;
    int pulses;
    applyReset();
    cfgNumResults = 16'd4;
    outReady      = 1'b1;
    accepts = 0;
    popIdx  = 0;
    lastPop = 0;
    pulses  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (tileDone) begin
        pulses++;
        checks++;
        if (lastPop != 4 && lastPop != 8) begin
          failures++;
          $display("[TB] FAIL tile_pulse_position got=pop%0d want=pop4_or_pop8", lastPop);
        end
      end
      if (outValid && outReady) begin
        popIdx++;
        lastPop = popIdx;
      end else begin
        lastPop = 0;
      end
      issueValid = (accepts < 8) && issueReady;
      issueData  = 16'(accepts + 1);
      @(negedge clk);
      if (issueValid) accepts++;
    end
    issueValid = 1'b0;
    outReady   = 1'b0;
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("[TB] FAIL tile_pulse_count got=%0d want=2", pulses);
    end
    checks++;
    if (popIdx !== 8) begin
      failures++;
      $display("[TB] FAIL tile_pop_count got=%0d want=8", popIdx);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    applyReset();
    for (int i = 0; i < 2; i++) begin
      issueValid = 1'b1;
      issueData  = 16'(16'h10 + i);
      @(negedge clk);
    end
    issueValid = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issueValid = 1'b1;
      issueData  = 16'(16'h20 + i);
      @(negedge clk);
    end
    issueValid = 1'b0;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1 || issueReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midflight_pre_state got valid=%b ready=%b want valid=1 ready=1",
               outValid, issueReady);
    end
    #2;
    arstN = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midflight_reset_out_valid got=%b want=0", outValid);
    end
    checks++;
    if (issueReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midflight_reset_issue_ready got=%b want=1", issueReady);
    end
    @(negedge clk);
    arstN    = 1'b1;
    outReady = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (outValid) stale++;
    end
    outReady = 1'b0;
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("[TB] FAIL midflight_stale_results got=%0d want=0", stale);
    end
    checks++;
    if (overflowErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midflight_overflow got=%b want=0", overflowErr);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single_issue();
    test_saturation();
    test_backpressure();
    test_protocol_violation();
    test_tiles();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
